sipo_rx: RTL and testbench

Serial-in, parallel-out word receiver: the receive end of our parallel-in/serial-out shift-register link. It collects a framed MSB-first bit stream one bit per enabled clock, assembles WIDTH-bit words, and presents each word on a registered output with a valid/ready handshake. It sits downstream of the PISO transmitter and upstream of any word-wide consumer.

---
 rtl/sipo_rx.sv | 119 +++++++++++
 tb/tb_sipo_rx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in, parallel-out word receiver: frames an MSB-first bit stream into
// WIDTH-bit words and hands each one out on a registered valid/ready port.
//
// state | meaning
// IDLE  | waiting for a bit tagged with frame_start
// SHIFT | partial word held in sr, cnt bits received so far
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             frame_start,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic [WIDTH-1:0] word;
    logic             word_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        word_done   = 1'b0;
        word        = {sr_q[WIDTH-2:0], sin};

        if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end

        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        sr_d    = word;
                        cnt_d   = CNT_W'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    sr_d = word;
                    if (frame_start) begin
                        // restart: the sampled bit is the MSB of a fresh word
                        frame_err_d = 1'b1;
                        cnt_d       = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        word_done = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // a held word may be replaced only if it is consumed on this same edge
        if (word_done) begin
            if (!valid_q || dout_ready) begin
                dout_d  = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = (state_q == SHIFT);
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: a bit-list reference model pushes expected words,
// a negedge monitor pops them on each observed handshake.
module tb_sipo_rx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         bit_en = 1'b0;
    logic         frame_start = 1'b0;
    logic         sin = 1'b0;
    logic         dout_ready = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         busy;
    logic         overrun;
    logic         frame_err;

    int checks = 0;
    int failures = 0;

    sipo_rx #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_en      (bit_en),
        .frame_start (frame_start),
        .sin         (sin),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .busy        (busy),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [W-1:0] sb[$];
    bit           bits[$];
    bit           in_frame = 0;
    bit           m_valid = 0;
    bit           exp_ovr = 0;
    bit           exp_fe = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: evaluates the word-level rules on each sampling edge
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                sb.delete();
                bits.delete();
                in_frame = 0;
                m_valid  = 0;
                exp_ovr  = 0;
                exp_fe   = 0;
            end else begin
                bit           done;
                bit           acc;
                logic [W-1:0] val;
                done    = 0;
                acc     = m_valid && dout_ready;
                exp_ovr = 0;
                exp_fe  = 0;
                val     = '0;
                if (bit_en) begin
                    if (frame_start) begin
                        if (in_frame) exp_fe = 1;
                        bits.delete();
                        bits.push_back(sin);
                        in_frame = 1;
                    end else if (in_frame) begin
                        bits.push_back(sin);
                        if (bits.size() == W) begin
                            foreach (bits[k]) val = (val << 1) | W'(bits[k]);
                            done = 1;
                            bits.delete();
                            in_frame = 0;
                        end
                    end
                end
                if (done) begin
                    if (!m_valid || dout_ready) begin
                        sb.push_back(val);
                        m_valid = 1;
                    end else begin
                        exp_ovr = 1;
                    end
                end else if (acc) begin
                    m_valid = 0;
                end
            end
        end
    end

    // monitor: mid-cycle, outputs and inputs are both stable
    initial begin
        forever begin
            @(negedge clk);
            chk("dout_valid", 32'(dout_valid), 32'(m_valid));
            chk("busy", 32'(busy), 32'(in_frame));
            chk("overrun", 32'(overrun), 32'(exp_ovr));
            chk("frame_err", 32'(frame_err), 32'(exp_fe));
            if (dout_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: dout_valid=1 with dout=%0h but no word expected at %0t", dout, $time);
                end else begin
                    chk("dout", 32'(dout), 32'(sb[0]));
                    if (dout_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step(input logic en, input logic fs, input logic s, input logic rdy);
        bit_en      = en;
        frame_start = fs;
        sin         = s;
        dout_ready  = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [W-1:0] v, input bit gaps, input logic rdy);
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b1, i == W - 1, v[i], rdy);
            if (gaps && i != 0) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #2;
        chk("init_valid", 32'(dout_valid), 32'h0);
        chk("init_dout", 32'(dout), 32'h0);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // 1,0,1,1 with bit_en held
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t1_busy_e1", 32'(busy), 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t1_busy_e3", 32'(busy), 32'h1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t1_dout", 32'(dout), 32'hB);
        chk("t1_valid", 32'(dout_valid), 32'h1);
        chk("t1_busy_e4", 32'(busy), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_valid_drop", 32'(dout_valid), 32'h0);

        // 0,1,1,0 with gaps
        send_word(4'h6, 1'b1, 1'b1);
        chk("t2_dout", 32'(dout), 32'h6);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // overrun: A then 5 with ready low
        send_word(4'hA, 1'b0, 1'b0);
        send_word(4'h5, 1'b0, 1'b0);
        chk("t3_overrun", 32'(overrun), 32'h1);
        chk("t3_dout", 32'(dout), 32'hA);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_overrun_pulse", 32'(overrun), 32'h0);
        chk("t3_valid_drop", 32'(dout_valid), 32'h0);

        // replace held 3 with C when ready on completing edge
        send_word(4'h3, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_dout", 32'(dout), 32'hC);
        chk("t4_valid", 32'(dout_valid), 32'h1);
        chk("t4_overrun", 32'(overrun), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // frame error on partial word
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_frame_err", 32'(frame_err), 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t5_frame_err_pulse", 32'(frame_err), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t5_dout", 32'(dout), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        chk("t5_idle_ignore", 32'(dout_valid), 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("t5_fs_no_en", 32'(busy), 32'h0);

        // reset mid-word, then with a held word
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        do_reset();
        send_word(4'h9, 1'b0, 1'b0);
        chk("t6_dout", 32'(dout), 32'h9);
        do_reset();
        send_word(4'h9, 1'b0, 1'b1);
        chk("t6_dout_again", 32'(dout), 32'h9);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0)
                send_word(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                step(1'($urandom_range(0, 3) != 0), $urandom_range(0, 4) == 0,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 79) == 0) do_reset();
        end

        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("drain_sb", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
